// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, control-bundle bit map and the NOP bundle.
package cpu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned CTRL_W     = 8;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMREAD  = 1;
  localparam int unsigned MEMWRITE = 2;
  localparam int unsigned MEMTOREG = 3;
  localparam int unsigned ALUSRC   = 4;
  localparam int unsigned BRANCH   = 5;
  localparam int unsigned ALUOP_LO = 6;
  localparam int unsigned ALUOP_HI = 7;

  // Field order puts regwrite at bit 0 so the struct overlays the bit map above.
  typedef struct packed {
    logic [1:0] aluop;
    logic       branch;
    logic       alusrc;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       regwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and front-end hold request; purely combinational.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  lu_c,
  output logic                  id_hold_c
);

  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign rs1_match = (ex_rd_addr_i == id_rs1_addr_i);
  assign rs2_match = id_rs2_used_i & (ex_rd_addr_i == id_rs2_addr_i);
  assign lu_c      = id_valid_i & ex_valid_i & ex_memread_i &
                     (ex_rd_addr_i != '0) & (rs1_match | rs2_match);

  // A flush discards the ID instruction anyway, so the front end must not hold.
  assign id_hold_c = ~flush_i & (stall_i | lu_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and writeback refresh of held operands.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_rs2_used_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [CTRL_W-1:0]     id_ctrl_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  wb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_imm_o,
  output logic [CTRL_W-1:0]     ex_ctrl_o,
  output logic                  id_hold_o,
  output logic [CNT_W-1:0]      lu_stall_cnt_o
);

  logic lu_c;
  logic wb_hit_rs1_c;
  logic wb_hit_rs2_c;
  logic cnt_sat_c;

  hazard_detect u_hazard_detect (
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_valid_i    (ex_valid_o),
    .ex_memread_i  (ex_ctrl_o[MEMREAD]),
    .ex_rd_addr_i  (ex_rd_addr_o),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .lu_c          (lu_c),
    .id_hold_c     (id_hold_o)
  );

  // The register file writes on negedge, so a held operand must pick up a retiring write itself.
  assign wb_hit_rs1_c = wb_regwrite_i & (wb_rd_addr_i != '0) & (wb_rd_addr_i == ex_rs1_addr_o);
  assign wb_hit_rs2_c = wb_regwrite_i & (wb_rd_addr_i != '0) & (wb_rd_addr_i == ex_rs2_addr_o);
  assign cnt_sat_c    = &lu_stall_cnt_o;

  // Priority: flush, then downstream stall, then load-use bubble, then normal load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_o     <= 1'b0;
      ex_pc_o        <= '0;
      ex_rs1_addr_o  <= '0;
      ex_rs2_addr_o  <= '0;
      ex_rd_addr_o   <= '0;
      ex_rs1_data_o  <= '0;
      ex_rs2_data_o  <= '0;
      ex_imm_o       <= '0;
      ex_ctrl_o      <= '0;
      lu_stall_cnt_o <= '0;
    end else if (flush_i) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= CTRL_NOP;
      ex_rd_addr_o <= '0;
    end else if (stall_i) begin
      if (wb_hit_rs1_c) ex_rs1_data_o <= wb_data_i;
      if (wb_hit_rs2_c) ex_rs2_data_o <= wb_data_i;
    end else if (lu_c) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= CTRL_NOP;
      ex_rd_addr_o <= '0;
      if (!cnt_sat_c) lu_stall_cnt_o <= lu_stall_cnt_o + CNT_W'(1);
    end else begin
      ex_valid_o    <= id_valid_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_ctrl_o     <= id_valid_i ? id_ctrl_i : CTRL_NOP;
      ex_rd_addr_o  <= id_valid_i ? id_rd_addr_i : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [63:0] id_pc_i = '0;
  logic [4:0]  id_rs1_addr_i = '0;
  logic [4:0]  id_rs2_addr_i = '0;
  logic [4:0]  id_rd_addr_i = '0;
  logic        id_rs2_used_i = 1'b0;
  logic [63:0] id_rs1_data_i = '0;
  logic [63:0] id_rs2_data_i = '0;
  logic [63:0] id_imm_i = '0;
  logic [7:0]  id_ctrl_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        wb_regwrite_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [63:0] wb_data_i = '0;

  logic             ex_valid_o;
  logic [63:0]      ex_pc_o;
  logic [4:0]       ex_rs1_addr_o;
  logic [4:0]       ex_rs2_addr_o;
  logic [4:0]       ex_rd_addr_o;
  logic [63:0]      ex_rs1_data_o;
  logic [63:0]      ex_rs2_data_o;
  logic [63:0]      ex_imm_o;
  logic [7:0]       ex_ctrl_o;
  logic             id_hold_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural picture of what EX should hold.
  typedef struct {
    bit          valid;
    logic [63:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [7:0]  ctrl;
    int          cnt;
  } ex_model_t;

  ex_model_t m;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_pc_i        (id_pc_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .id_rs1_data_i  (id_rs1_data_i),
    .id_rs2_data_i  (id_rs2_data_i),
    .id_imm_i       (id_imm_i),
    .id_ctrl_i      (id_ctrl_i),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_data_i      (wb_data_i),
    .ex_valid_o     (ex_valid_o),
    .ex_pc_o        (ex_pc_o),
    .ex_rs1_addr_o  (ex_rs1_addr_o),
    .ex_rs2_addr_o  (ex_rs2_addr_o),
    .ex_rd_addr_o   (ex_rd_addr_o),
    .ex_rs1_data_o  (ex_rs1_data_o),
    .ex_rs2_data_o  (ex_rs2_data_o),
    .ex_imm_o       (ex_imm_o),
    .ex_ctrl_o      (ex_ctrl_o),
    .id_hold_o      (id_hold_o),
    .lu_stall_cnt_o (lu_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m = '{valid: 1'b0, pc: '0, rs1a: '0, rs2a: '0, rd: '0, rs1d: '0, rs2d: '0,
          imm: '0, ctrl: '0, cnt: 0};
  endfunction

  // An instruction must wait if a load sitting in EX writes a register it reads.
  function automatic bit model_lu();
    bool_reads_it: begin end
    return id_valid_i && m.valid && m.ctrl[1] && m.rd != 0 &&
           (m.rd == id_rs1_addr_i || (id_rs2_used_i && m.rd == id_rs2_addr_i));
  endfunction

  task automatic check_state();
    check("ex_valid",  64'(ex_valid_o),     64'(m.valid));
    check("ex_pc",     ex_pc_o,             m.pc);
    check("ex_rs1a",   64'(ex_rs1_addr_o),  64'(m.rs1a));
    check("ex_rs2a",   64'(ex_rs2_addr_o),  64'(m.rs2a));
    check("ex_rd",     64'(ex_rd_addr_o),   64'(m.rd));
    check("ex_rs1d",   ex_rs1_data_o,       m.rs1d);
    check("ex_rs2d",   ex_rs2_data_o,       m.rs2d);
    check("ex_imm",    ex_imm_o,            m.imm);
    check("ex_ctrl",   64'(ex_ctrl_o),      64'(m.ctrl));
    check("lu_cnt",    64'(lu_stall_cnt_o), 64'(m.cnt));
  endtask

  // Called at posedge+1 with inputs set: checks mid-cycle, then advances model across the edge.
  task automatic step();
    bit lu;
    bit hold;
    ex_model_t nx;
    #3;
    lu   = model_lu();
    hold = !flush_i && (stall_i || lu);
    check("id_hold", 64'(id_hold_o), 64'(hold));
    check_state();
    nx = m;
    if (flush_i) begin
      nx.valid = 1'b0; nx.ctrl = '0; nx.rd = '0;
    end else if (stall_i) begin
      if (wb_regwrite_i && wb_rd_addr_i != 0 && wb_rd_addr_i == m.rs1a) nx.rs1d = wb_data_i;
      if (wb_regwrite_i && wb_rd_addr_i != 0 && wb_rd_addr_i == m.rs2a) nx.rs2d = wb_data_i;
    end else if (lu) begin
      nx.valid = 1'b0; nx.ctrl = '0; nx.rd = '0;
      if (nx.cnt < CNT_MAX) nx.cnt = nx.cnt + 1;
    end else begin
      nx.valid = id_valid_i;
      nx.pc    = id_pc_i;
      nx.rs1a  = id_rs1_addr_i;
      nx.rs2a  = id_rs2_addr_i;
      nx.rs1d  = id_rs1_data_i;
      nx.rs2d  = id_rs2_data_i;
      nx.imm   = id_imm_i;
      nx.ctrl  = id_valid_i ? id_ctrl_i : 8'h00;
      nx.rd    = id_valid_i ? id_rd_addr_i : 5'd0;
    end
    @(posedge clk_i);
    #1;
    m = nx;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input bit used,
                        input logic [4:0] rd, input logic [7:0] ctrl);
    id_valid_i    = 1'b1;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_rs2_used_i = used;
    id_rd_addr_i  = rd;
    id_ctrl_i     = ctrl;
    id_pc_i       = {$urandom, $urandom};
    id_rs1_data_i = {$urandom, $urandom};
    id_rs2_data_i = {$urandom, $urandom};
    id_imm_i      = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] saved_pc;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Normal flow.
    set_id(5'd1, 5'd2, 1'b0, 5'd4, 8'h01);
    id_pc_i = 64'h100; id_rs1_data_i = 64'd5; id_imm_i = -64'sd4;
    step();
    #3;
    check("flow_pc",    ex_pc_o,            64'h100);
    check("flow_rs1d",  ex_rs1_data_o,      64'd5);
    check("flow_imm",   ex_imm_o,           64'hFFFF_FFFF_FFFF_FFFC);
    check("flow_valid", 64'(ex_valid_o),    64'd1);
    @(posedge clk_i); #1;
    set_id(5'd9, 5'd9, 1'b0, 5'd9, 8'h00);
    step();

    // Load-use via rs2.
    set_id(5'd1, 5'd2, 1'b0, 5'd7, 8'h03);
    step();
    set_id(5'd1, 5'd7, 1'b1, 5'd8, 8'h01);
    #3;
    check("lu_hold", 64'(id_hold_o), 64'd1);
    #2; @(posedge clk_i); #1;
    m.valid = 1'b0; m.ctrl = '0; m.rd = '0; m.cnt = 1;
    #3;
    check("lu_bubble_valid", 64'(ex_valid_o),     64'd0);
    check("lu_bubble_ctrl",  64'(ex_ctrl_o),      64'd0);
    check("lu_cnt_one",      64'(lu_stall_cnt_o), 64'd1);
    check("lu_hold_drop",    64'(id_hold_o),      64'd0);
    #2; @(posedge clk_i); #1;
    m.valid = 1'b1; m.pc = id_pc_i; m.rs1a = 5'd1; m.rs2a = 5'd7; m.rd = 5'd8;
    m.rs1d = id_rs1_data_i; m.rs2d = id_rs2_data_i; m.imm = id_imm_i; m.ctrl = 8'h01;
    check_state();

    // Load to x0 never stalls.
    set_id(5'd1, 5'd2, 1'b0, 5'd0, 8'h02);
    step();
    set_id(5'd0, 5'd0, 1'b1, 5'd5, 8'h01);
    #3;
    check("x0_no_hold", 64'(id_hold_o), 64'd0);
    #2; @(posedge clk_i); #1;
    m.valid = 1'b1; m.pc = id_pc_i; m.rs1a = 5'd0; m.rs2a = 5'd0; m.rd = 5'd5;
    m.rs1d = id_rs1_data_i; m.rs2d = id_rs2_data_i; m.imm = id_imm_i; m.ctrl = 8'h01;
    check_state();

    // Writeback refresh while stalled.
    set_id(5'd3, 5'd4, 1'b1, 5'd6, 8'h11);
    id_rs1_data_i = '0;
    step();
    saved_pc = id_pc_i;
    stall_i = 1'b1; wb_regwrite_i = 1'b1; wb_rd_addr_i = 5'd3; wb_data_i = 64'hABCD;
    set_id(5'd10, 5'd11, 1'b1, 5'd12, 8'h01);
    step();
    #3;
    check("refresh_rs1d", ex_rs1_data_o, 64'hABCD);
    check("refresh_pc",   ex_pc_o,       saved_pc);
    #2; @(posedge clk_i); #1;
    wb_rd_addr_i = 5'd0; wb_data_i = 64'h1234;
    step();
    #3;
    check("refresh_x0", ex_rs1_data_o, 64'hABCD);
    #2; @(posedge clk_i); #1;
    stall_i = 1'b0; wb_regwrite_i = 1'b0;
    step();

    // Flush beats stall and load-use.
    set_id(5'd1, 5'd2, 1'b0, 5'd7, 8'h02);
    step();
    set_id(5'd7, 5'd2, 1'b0, 5'd9, 8'h01);
    stall_i = 1'b1; flush_i = 1'b1;
    #3;
    check("flush_hold", 64'(id_hold_o), 64'd0);
    #2; @(posedge clk_i); #1;
    m.valid = 1'b0; m.ctrl = '0; m.rd = '0;
    #3;
    check("flush_valid", 64'(ex_valid_o),     64'd0);
    check("flush_ctrl",  64'(ex_ctrl_o),      64'd0);
    check("flush_cnt",   64'(lu_stall_cnt_o), 64'd1);
    #2; @(posedge clk_i); #1;
    stall_i = 1'b0; flush_i = 1'b0;

    // Drive the counter into saturation.
    for (int i = 0; i < 17; i++) begin
      set_id(5'd1, 5'd2, 1'b0, 5'd7, 8'h02);
      step();
      set_id(5'd7, 5'd2, 1'b0, 5'd9, 8'h01);
      step();
      step();
    end
    #3;
    check("sat_cnt", 64'(lu_stall_cnt_o), 64'(CNT_MAX));
    check("sat_valid_before_rst", 64'(ex_valid_o), 64'd1);

    // Asynchronous reset mid-cycle.
    rst_i = 1'b0;
    #1;
    check("rst_valid", 64'(ex_valid_o),     64'd0);
    check("rst_pc",    ex_pc_o,             64'd0);
    check("rst_ctrl",  64'(ex_ctrl_o),      64'd0);
    check("rst_cnt",   64'(lu_stall_cnt_o), 64'd0);
    model_reset();
    check_state();
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Random traffic with a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 8'($urandom));
      id_valid_i    = ($urandom_range(0, 7) != 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      stall_i       = ($urandom_range(0, 4) == 0);
      wb_regwrite_i = 1'($urandom);
      wb_rd_addr_i  = 5'($urandom_range(0, 3));
      wb_data_i     = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
